// File: rtl/uart_aim_receiver_pkg.sv
// Shared types and constants for the UART current-aim receiver.
// Parser/receiver state encodings, ASCII byte codes and the field saturation helper.
package uart_aim_receiver_pkg;

    typedef enum logic [2:0] {
        S_F0  = 3'd0,
        S_N0  = 3'd1,
        S_F1  = 3'd2,
        S_N1  = 3'd3,
        S_END = 3'd4,
        S_ERR = 3'd5
    } parser_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Unsigned magnitude plus sign flag -> saturated 16-bit two's complement.
    function automatic logic [15:0] sat_field(input logic [16:0] mag, input logic neg);
        logic [16:0] neg_mag;
        neg_mag = 17'd0 - mag;
        if (neg) begin
            return (mag > 17'd32768) ? 16'h8000 : neg_mag[15:0];
        end
        return (mag > 17'd32767) ? 16'h7FFF : mag[15:0];
    endfunction

endpackage

// File: rtl/uart_aim_receiver_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, falling-edge start detect, mid-bit sampling.
// Emits a one-cycle valid pulse with the byte, or a framing-error pulse on a low stop bit.
module uart_rx_byte
    import uart_aim_receiver_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd320
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam logic [15:0] HALF_DIV = CLK_DIV >> 1;

    logic        sync1_q, sync2_q, prev_q;
    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    // Line idles high, so the synchronizer resets high and a fresh falling edge is required.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_DIV - 16'd1;
                end
            end
            RX_START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (sync2_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    cnt_d   = CLK_DIV - 16'd1;
                    bit_d   = 3'd0;
                end
            end
            RX_DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = CLK_DIV - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_aim_receiver.sv
// Receives "<id> <iq>" ASCII lines over UART and publishes saturated signed current targets.
// state | meaning
// S_F0  | await field 1 (blank lines ignored)
// S_N0  | in field 1 digits
// S_F1  | await field 2
// S_N1  | in field 2 digits
// S_END | trailing spaces before CR/LF
// S_ERR | discard until CR/LF, then pulse o_err
module uart_aim_receiver
    import uart_aim_receiver_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd320
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_uart_rx,
    output logic               o_en,
    output logic signed [15:0] o_id_aim,
    output logic signed [15:0] o_iq_aim,
    output logic               o_err
);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk          (clk),
        .rstn         (rstn),
        .rx_i         (i_uart_rx),
        .byte_valid_o (rx_valid),
        .byte_data_o  (rx_data),
        .frame_err_o  (rx_ferr)
    );

    parser_state_e state_q, state_d;
    logic [16:0]   acc_q, acc_d;
    logic          neg_q, neg_d;
    logic [2:0]    ndig_q, ndig_d;
    logic [15:0]   id_fld_q, id_fld_d;
    logic [15:0]   id_q, id_d;
    logic [15:0]   iq_q, iq_d;
    logic          en_q, en_d;
    logic          err_q, err_d;

    logic        is_digit, is_space, is_sep, is_minus, is_eol, bad;
    logic [16:0] acc_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_F0;
            acc_q    <= 17'd0;
            neg_q    <= 1'b0;
            ndig_q   <= 3'd0;
            id_fld_q <= 16'd0;
            id_q     <= 16'd0;
            iq_q     <= 16'd0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            ndig_q   <= ndig_d;
            id_fld_q <= id_fld_d;
            id_q     <= id_d;
            iq_q     <= iq_d;
            en_q     <= en_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
        is_space = (rx_data == ASCII_SPACE);
        is_sep   = is_space || (rx_data == ASCII_COMMA);
        is_minus = (rx_data == ASCII_MINUS);
        is_eol   = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
        acc_next = (acc_q * 17'd10) + {13'd0, rx_data[3:0]};

        state_d  = state_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        ndig_d   = ndig_q;
        id_fld_d = id_fld_q;
        id_d     = id_q;
        iq_d     = iq_q;
        en_d     = 1'b0;
        err_d    = 1'b0;
        bad      = 1'b0;

        if (rx_ferr) begin
            state_d = S_ERR;
        end else if (rx_valid) begin
            case (state_q)
                S_F0, S_F1: begin
                    if (is_minus || is_digit) begin
                        state_d = (state_q == S_F0) ? S_N0 : S_N1;
                        neg_d   = is_minus;
                        acc_d   = is_digit ? {13'd0, rx_data[3:0]} : 17'd0;
                        ndig_d  = is_digit ? 3'd1 : 3'd0;
                    end else if (state_q == S_F0) begin
                        bad = !(is_space || is_eol);
                    end else begin
                        bad = !is_sep;
                    end
                end
                S_N0, S_N1: begin
                    if (is_digit) begin
                        if (ndig_q == 3'd5) begin
                            bad = 1'b1;
                        end else begin
                            acc_d  = acc_next;
                            ndig_d = ndig_q + 3'd1;
                        end
                    end else if (ndig_q == 3'd0) begin
                        bad = 1'b1;
                    end else if (state_q == S_N0 && is_sep) begin
                        id_fld_d = sat_field(acc_q, neg_q);
                        state_d  = S_F1;
                    end else if (state_q == S_N1 && is_space) begin
                        state_d = S_END;
                    end else if (state_q == S_N1 && is_eol) begin
                        id_d    = id_fld_q;
                        iq_d    = sat_field(acc_q, neg_q);
                        en_d    = 1'b1;
                        state_d = S_F0;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_END: begin
                    if (is_eol) begin
                        id_d    = id_fld_q;
                        iq_d    = sat_field(acc_q, neg_q);
                        en_d    = 1'b1;
                        state_d = S_F0;
                    end else if (!is_space) begin
                        bad = 1'b1;
                    end
                end
                S_ERR: begin
                    bad = 1'b1;
                end
                default: state_d = S_F0;
            endcase

            // A CR/LF that breaks the grammar also terminates the line, so report at once.
            if (bad) begin
                if (is_eol) begin
                    err_d   = 1'b1;
                    state_d = S_F0;
                end else begin
                    state_d = S_ERR;
                end
            end
        end
    end

    assign o_en     = en_q;
    assign o_err    = err_q;
    assign o_id_aim = id_q;
    assign o_iq_aim = iq_q;

endmodule

// File: tb/tb_uart_aim_receiver.sv
// Directed bench for uart_aim_receiver: serial line stimulus, pulse counters, immediate-assert checks.
module tb_uart_aim_receiver;

    localparam logic [15:0] CLK_DIV = 16'd40;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               rx = 1'b1;
    logic               en, err;
    logic signed [15:0] id_aim, iq_aim;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int en_base, err_base;

    uart_aim_receiver #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_uart_rx (rx),
        .o_en      (en),
        .o_id_aim  (id_aim),
        .o_iq_aim  (iq_aim),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en) en_cnt++;
        if (err) err_cnt++;
        if (en && err) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (int'(CLK_DIV)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bit_time();
        end
        rx = stop;
        bit_time();
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic mark();
        en_base  = en_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_id", int'(id_aim), 0);
        check("rst_iq", int'(iq_aim), 0);
        check("rst_en", int'(en), 0);
        check("rst_err", int'(err), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        mark();
        send_line("0 200\n");
        check("l1_en", en_cnt - en_base, 1);
        check("l1_err", err_cnt - err_base, 0);
        check("l1_id", int'(id_aim), 0);
        check("l1_iq", int'(iq_aim), 200);

        mark();
        send_line("  -15,-200\r\n");
        check("l2_en", en_cnt - en_base, 1);
        check("l2_id", int'(id_aim), -15);
        check("l2_iq", int'(iq_aim), -200);

        mark();
        send_line("99999 -40000\n");
        check("sat_en", en_cnt - en_base, 1);
        check("sat_id", int'(id_aim), 32767);
        check("sat_iq", int'(iq_aim), -32768);

        mark();
        send_line("123456 1\n");
        check("six_err", err_cnt - err_base, 1);
        check("six_en", en_cnt - en_base, 0);
        check("six_id", int'(id_aim), 32767);
        check("six_iq", int'(iq_aim), -32768);

        mark();
        send_line("12 x\n");
        send_line("- 5\n");
        send_line("\n");
        check("bad_err", err_cnt - err_base, 2);
        check("bad_en", en_cnt - en_base, 0);
        check("bad_id", int'(id_aim), 32767);
        check("bad_iq", int'(iq_aim), -32768);

        mark();
        send_byte("7", 1'b1);
        send_byte(" ", 1'b1);
        send_byte("8", 1'b0);
        send_byte(8'h0A, 1'b1);
        repeat (10) @(negedge clk);
        check("frm_err", err_cnt - err_base, 1);
        check("frm_en", en_cnt - en_base, 0);
        check("frm_id", int'(id_aim), 32767);
        check("frm_iq", int'(iq_aim), -32768);

        mark();
        send_line("7 8\n");
        check("frm2_en", en_cnt - en_base, 1);
        check("frm2_id", int'(id_aim), 7);
        check("frm2_iq", int'(iq_aim), 8);

        // Short low glitch must not be taken as a start bit.
        mark();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12 * int'(CLK_DIV)) @(negedge clk);
        send_line("5 6\n");
        check("glt_en", en_cnt - en_base, 1);
        check("glt_err", err_cnt - err_base, 0);
        check("glt_id", int'(id_aim), 5);
        check("glt_iq", int'(iq_aim), 6);

        send_byte("1", 1'b1);
        send_byte("0", 1'b1);
        rx = 1'b0;
        repeat (3 * int'(CLK_DIV)) @(negedge clk);
        rstn = 1'b0;
        rx = 1'b1;
        #1;
        check("mrst_id", int'(id_aim), 0);
        check("mrst_iq", int'(iq_aim), 0);
        check("mrst_en", int'(en), 0);
        check("mrst_err", int'(err), 0);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        mark();
        send_line("3 4\n");
        check("post_en", en_cnt - en_base, 1);
        check("post_err", err_cnt - err_base, 0);
        check("post_id", int'(id_aim), 3);
        check("post_iq", int'(iq_aim), 4);

        check("en_err_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
